// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM fade control slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

  // Default widths; modules expose them as overridable parameters.
  localparam int DEFAULT_VALUE_W = 8;
  localparam int DEFAULT_DIV_W   = 8;

  typedef logic [DEFAULT_VALUE_W-1:0] pwm_val_t;
  typedef logic [DEFAULT_DIV_W-1:0]   pwm_div_t;

  // Controller sequencing: wait for accept, arm on a period boundary,
  // ramp on period boundaries, then a one-cycle completion state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RAMP = 2'd2,
    DONE = 2'd3
  } fade_state_e;

  // One fade request as presented on the command interface.
  typedef struct packed {
    pwm_val_t target;
    pwm_val_t range;
    pwm_val_t step;
    pwm_div_t div;
    logic     en;
  } fade_cmd_t;

endpackage

// File: rtl/pwm_step_calc.sv
// Saturating one-step move of a duty value toward a target, never overshooting.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module pwm_step_calc
  import pwm_pkg::*;
#(
  parameter int W = DEFAULT_VALUE_W
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] target,
  input  logic [W-1:0] step,
  output logic [W-1:0] next
);

  // One extra bit so the add cannot wrap and the subtract exposes underflow.
  logic [W:0] sum;
  logic [W:0] diff;

  assign sum  = {1'b0, cur} + {1'b0, step};
  assign diff = {1'b0, cur} - {1'b0, step};

  // Pick the stepped value only while it stays strictly short of the target;
  // anything reaching or crossing the target lands exactly on it.
  always_comb begin
    next = target;
    if (step != '0) begin
      if (cur < target) begin
        if (sum < {1'b0, target}) begin
          next = sum[W-1:0];
        end
      end else if (cur > target) begin
        if (!diff[W] && (diff > {1'b0, target})) begin
          next = diff[W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Ramps the PWM generator's duty toward a commanded target, one step per N periods.
// Latency: outputs registered; changes land only on pwm_period cycles, done one cycle after the final step.
// Backpressure: cmd_ready is high only in IDLE; a pending command is held off until the fade completes.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int VALUE_W = DEFAULT_VALUE_W,
  parameter int DIV_W   = DEFAULT_DIV_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [VALUE_W-1:0] cmd_target,
  input  logic [VALUE_W-1:0] cmd_range,
  input  logic [VALUE_W-1:0] cmd_step,
  input  logic [DIV_W-1:0]   cmd_div,
  input  logic               cmd_en,
  input  logic               pwm_period,
  output logic [VALUE_W-1:0] pwm_value,
  output logic [VALUE_W-1:0] pwm_range,
  output logic               pwm_en,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_ARM  = ARM;
  localparam logic [1:0] ST_RAMP = RAMP;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [1:0]         state;

  // Latched command, already reduced to the values the ramp actually uses.
  logic [VALUE_W-1:0] tgt_q;
  logic [VALUE_W-1:0] rng_q;
  logic [VALUE_W-1:0] step_q;
  logic [DIV_W-1:0]   div_q;
  logic               en_q;
  logic [DIV_W-1:0]   div_cnt;

  logic               cmd_fire;
  logic [VALUE_W-1:0] eff_target;
  logic [DIV_W-1:0]   div_eff;
  logic [VALUE_W-1:0] step_next;
  logic               at_target;
  logic               step_due;

  // Ready is a pure state decode so upstream sees no input-to-output path.
  assign cmd_ready = (state == ST_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;

  // A disable command always fades to zero; otherwise never aim past the range.
  assign eff_target = !cmd_en ? '0 : ((cmd_target < cmd_range) ? cmd_target : cmd_range);
  assign div_eff    = (cmd_div == '0) ? DIV_ONE : cmd_div;

  assign at_target = (pwm_value == tgt_q);
  assign step_due  = (div_cnt == (div_q - DIV_ONE));

  pwm_step_calc #(
    .W (VALUE_W)
  ) u_step_calc (
    .cur    (pwm_value),
    .target (tgt_q),
    .step   (step_q),
    .next   (step_next)
  );

  // Sequencer: every output update is gated by pwm_period so the generator
  // never sees a duty, range or enable change in the middle of a period.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pwm_value <= '0;
      pwm_range <= '0;
      pwm_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tgt_q     <= '0;
      rng_q     <= '0;
      step_q    <= '0;
      div_q     <= DIV_ONE;
      en_q      <= 1'b0;
      div_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            tgt_q   <= eff_target;
            rng_q   <= cmd_range;
            step_q  <= cmd_step;
            div_q   <= div_eff;
            en_q    <= cmd_en;
            div_cnt <= '0;
            busy    <= 1'b1;
            state   <= ST_ARM;
          end
        end

        ST_ARM: begin
          // First boundary after accept: apply the new range and clamp the
          // current duty into it before any stepping starts.
          if (pwm_period) begin
            pwm_range <= rng_q;
            if (en_q) begin
              pwm_en <= 1'b1;
            end
            if (pwm_value > rng_q) begin
              pwm_value <= rng_q;
            end
            state <= ST_RAMP;
          end
        end

        ST_RAMP: begin
          if (pwm_period) begin
            if (at_target) begin
              // Already there (e.g. after the arm clamp): finish without a step.
              if (!en_q) begin
                pwm_en <= 1'b0;
              end
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else if (step_due) begin
              div_cnt   <= '0;
              pwm_value <= step_next;
              if (step_next == tgt_q) begin
                if (!en_q) begin
                  pwm_en <= 1'b0;
                end
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= ST_DONE;
              end
            end else begin
              div_cnt <= div_cnt + DIV_ONE;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
- Upstream control stage for the PWM generator. Drives its pwm_value, pwm_range and pwm_en inputs, and consumes its pwm_period boundary pulse.
- Accepts a fade command: target duty, range, step size and periods-per-step. It then ramps pwm_value toward the target, changing it only at PWM period boundaries, so the generator never sees a mid-period duty change.
- A command with en=0 fades the output to 0, then drops pwm_en.

Parameters:
- VALUE_W, 8, width of pwm_value, pwm_range, cmd_target, cmd_range and cmd_step.
- DIV_W, 8, width of cmd_div (PWM periods per ramp step).

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_target  input  VALUE_W  final duty value.
- cmd_range  input  VALUE_W  PWM range to apply.
- cmd_step  input  VALUE_W  increment per step; 0 = jump directly to target.
- cmd_div  input  DIV_W  PWM periods per step; 0 treated as 1.
- cmd_en  input  1  1 = fade to target with PWM enabled; 0 = fade to 0, then disable.
- pwm_period  input  1  one-cycle pulse from the PWM generator marking the end of a period.
- pwm_value  output  VALUE_W  duty value to the generator.
- pwm_range  output  VALUE_W  range to the generator.
- pwm_en  output  1  generator enable.
- busy  output  1  fade in progress.
- done  output  1  one-cycle pulse when the fade completes.

Behaviour:
- Reset values: pwm_value=0, pwm_range=0, pwm_en=0, busy=0, done=0, cmd_ready=1. State is IDLE. Reset mid-fade aborts immediately, and these values apply the cycle after reset is sampled.
- Outputs are registered. No combinational path from any input to any output except cmd_ready, which is decoded from state only.
- Handshake: a command is accepted on a cycle with cmd_valid & cmd_ready. cmd_ready=1 only in IDLE; commands presented while busy are held off, not dropped.
- On accept, latch the command fields:
  - eff_target = cmd_en ? min(cmd_target, cmd_range) : 0
  - div_eff = (cmd_div==0) ? 1 : cmd_div
  - clear div_cnt; go to ARM; busy=1 from the next cycle.
- ARM, on the first pwm_period pulse:
  - pwm_range <= latched range.
  - If cmd_en=1, pwm_en <= 1.
  - If the current pwm_value > new range, pwm_value <= new range (clamp).
  - Go to RAMP.
  - pwm_period coinciding with the accept cycle does not count; ARM waits for the next pulse.
- RAMP, on each pwm_period pulse:
  - If div_cnt == div_eff-1: apply one step and set div_cnt <= 0.
  - Otherwise div_cnt <= div_cnt+1.
  - Cycles without a pulse hold everything.
- Step arithmetic uses VALUE_W+1 bits internally, with no wrap:
  - Up: next = cur+step; if next >= eff_target, next = eff_target.
  - Down: next = cur-step; if it underflows or next <= eff_target, next = eff_target.
  - step=0 means next = eff_target.
- If cur == eff_target on entry to RAMP, go straight to DONE in the same cycle without a step.
- When pwm_value becomes eff_target:
  - If the latched cmd_en=0, pwm_en <= 0 in the same cycle.
  - State goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0; next state IDLE (cmd_ready=1).
- pwm_value, pwm_range and pwm_en change only on cycles where pwm_period=1; they are stable otherwise. This is the key invariant for the bench.

Decomposition:
- Shared package pwm_pkg:
  - VALUE_W and DIV_W default constants.
  - Typedef pwm_val_t = logic [VALUE_W-1:0].
  - Typedef fade_state_e enum {IDLE, ARM, RAMP, DONE}.
  - Typedef fade_cmd_t struct {target, range, step, div, en}.
- One natural sub-module: pwm_step_calc. It is combinational: cur, target and step in, saturated next value out. It is unit-testable in isolation.

Test Plan:
- Reset, then cmd target=100, range=200, step=10, div=1, en=1 -> pwm_en=1 and pwm_range=200 at the 1st pwm_period; pwm_value 10,20,…,100 on pulses 2–11; done pulse on the 11th; cmd_ready back to 1.
- From value 100: target=0, step=30, div=2, en=0 -> value 70,40,10,0, changing only every 2nd pulse; pwm_en falls on the same cycle value reaches 0.
- target=250, range=128 -> eff_target=128; step=50 gives 50,100,128 (saturates, no overshoot).
- value 200 running, new cmd range=64, target=64 -> at the ARM boundary, range=64 and value clamps to 64; done on the next pulse, with no step.
- step=0, div=0 -> value jumps to target on the first RAMP pulse; cmd_valid held high while busy is accepted only once, after done.
- Assert reset mid-RAMP with the same-cycle pwm_period -> next cycle all outputs at reset values and state IDLE; monitor confirms outputs never change off a pwm_period cycle.
